delayprog_multi: RTL and testbench

- Parametrised, clocked successor to the fixed 10 ns rise-edge delay cell.
- Provides NCH independent channels. Each channel has a runtime-programmable delay in clock cycles and a selectable edge mode: rise, fall, both or bypass.
- Input pulses shorter than the programmed delay are swallowed, so the block doubles as a glitch filter.
- Sits between the loop control logic and downstream timing nodes, replacing per-instance fixed delay cells.

---
 rtl/delayprog_pkg.sv | 39 +++
 rtl/delayprog_chan.sv | 137 +++++++++++++
 rtl/delayprog_multi.sv | 52 +++++
 tb/tb_delayprog_multi.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/delayprog_pkg.sv
`default_nettype none
// ============================================================================
// Module   : delayprog_pkg
// Brief    : Shared types and defaults for the programmable delay cell.
// Revision : 1.0 - initial release
// ============================================================================
package delayprog_pkg;

  // Per-channel edge mode, encoded as the 2-bit mode field of each channel.
  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_BYP  = 2'b11
  } mode_e;

  // Channel FSM states; the output level is implied by the state.
  typedef enum logic [1:0] {
    LO = 2'b00,
    DR = 2'b01,
    HI = 2'b10,
    DF = 2'b11
  } state_e;

  localparam int CNTW_DEF = 8;
  localparam int SYNC_DEF = 2;

  // True when the mode delays rising edges.
  function automatic logic delays_rise(input logic [1:0] m);
    return (m == MODE_RISE) || (m == MODE_BOTH);
  endfunction

  // True when the mode delays falling edges.
  function automatic logic delays_fall(input logic [1:0] m);
    return (m == MODE_FALL) || (m == MODE_BOTH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/delayprog_chan.sv
`default_nettype none
// ============================================================================
// Module   : delayprog_chan
// Brief    : One delay channel: input synchroniser, edge FSM, down-counter
//            and sticky glitch flag.
// Revision : 1.0 - initial release
// ============================================================================
module delayprog_chan
  import delayprog_pkg::*;
#(
  parameter int CNTW = CNTW_DEF,
  parameter int SYNC = SYNC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            vdd,
  input  logic            gnd,
  input  logic            sub,
  input  logic            i,
  input  logic            en,
  input  logic [1:0]      mode,
  input  logic [CNTW-1:0] dly,
  input  logic            glitch_clr,
  output logic            o,
  output logic            busy,
  output logic            glitch
);

  // A single flop is not a synchroniser; shallower requests are raised to 2.
  localparam int SD = (SYNC < 2) ? 2 : SYNC;

  localparam logic [1:0] ST_LO = LO;
  localparam logic [1:0] ST_DR = DR;
  localparam logic [1:0] ST_HI = HI;
  localparam logic [1:0] ST_DF = DF;

  logic [SD-1:0]   sync_q;
  logic            is;
  logic [1:0]      state;
  logic [CNTW-1:0] cnt;
  logic            glitch_set;
  logic            unused_supply;

  // Supply pins are carried for netlist compatibility only.
  assign unused_supply = vdd ^ gnd ^ sub;

  assign is = sync_q[SD-1];

  // Synchroniser shift chain; runs independently of the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SD-2:0], i};
  end

  // A pending edge is cancelled when the input returns before the count ends.
  always_comb begin
    glitch_set = 1'b0;
    if (en) begin
      glitch_set = ((state == ST_DR) && !is) || ((state == ST_DF) && is);
    end
  end

  // Edge FSM with counter; mode and dly are only captured when a count starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LO;
      cnt   <= '0;
      o     <= 1'b0;
      busy  <= 1'b0;
    end else if (!en) begin
      state <= ST_LO;
      cnt   <= '0;
      o     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_LO: begin
          if (is) begin
            if (delays_rise(mode)) begin
              state <= ST_DR;
              cnt   <= dly;
              busy  <= 1'b1;
            end else begin
              state <= ST_HI;
              o     <= 1'b1;
            end
          end
        end
        ST_HI: begin
          if (!is) begin
            if (delays_fall(mode)) begin
              state <= ST_DF;
              cnt   <= dly;
              busy  <= 1'b1;
            end else begin
              state <= ST_LO;
              o     <= 1'b0;
            end
          end
        end
        ST_DR: begin
          if (!is) begin
            state <= ST_LO;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= ST_HI;
            o     <= 1'b1;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          if (is) begin
            state <= ST_HI;
            busy  <= 1'b0;
          end else if (cnt == '0) begin
            state <= ST_LO;
            o     <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
      endcase
    end
  end

  // Sticky glitch flag; a new cancellation beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          glitch <= 1'b0;
    else if (glitch_set) glitch <= 1'b1;
    else if (glitch_clr) glitch <= 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/delayprog_multi.sv
`default_nettype none
// ============================================================================
// Module   : delayprog_multi
// Brief    : NCH independent programmable delay / glitch-filter channels.
// Revision : 1.0 - initial release
// ============================================================================
module delayprog_multi
  import delayprog_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int CNTW = CNTW_DEF,
  parameter int SYNC = SYNC_DEF
) (
  input  logic                CELCLK,
  input  logic                CELRSTN,
  input  logic                CELV,
  input  logic                CELG,
  input  logic                CELSUB,
  input  logic [NCH-1:0]      i,
  input  logic [NCH-1:0]      en,
  input  logic [2*NCH-1:0]    mode,
  input  logic [CNTW*NCH-1:0] dly,
  input  logic [NCH-1:0]      glitch_clr,
  output logic [NCH-1:0]      o,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      glitch
);

  // One channel per bit; mode and dly are sliced per channel.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    delayprog_chan #(
      .CNTW (CNTW),
      .SYNC (SYNC)
    ) u_chan (
      .clk        (CELCLK),
      .rst_n      (CELRSTN),
      .vdd        (CELV),
      .gnd        (CELG),
      .sub        (CELSUB),
      .i          (i[c]),
      .en         (en[c]),
      .mode       (mode[2*c +: 2]),
      .dly        (dly[CNTW*c +: CNTW]),
      .glitch_clr (glitch_clr[c]),
      .o          (o[c]),
      .busy       (busy[c]),
      .glitch     (glitch[c])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_delayprog_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_delayprog_multi
// Brief    : Scoreboard bench for delayprog_multi (NCH=4, CNTW=8, SYNC=2).
//            Expected output edges are queued with their absolute clock edge
//            number; a monitor pops and compares whenever any o bit toggles.
//            Timing: input driven just after edge t; an undelayed edge shows
//            at edge t+SYNC+1, a delayed edge at edge t+SYNC+1+D+1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delayprog_multi;

  localparam int NCH  = 4;
  localparam int CNTW = 8;
  localparam int SYNC = 2;

  typedef struct {
    int   ch;
    logic val;
    int   cyc;
  } exp_t;

  logic              CELCLK;
  logic              CELRSTN;
  logic              CELV;
  logic              CELG;
  logic              CELSUB;
  logic [NCH-1:0]    i;
  logic [NCH-1:0]    en;
  logic [2*NCH-1:0]  mode;
  logic [CNTW*NCH-1:0] dly;
  logic [NCH-1:0]    glitch_clr;
  logic [NCH-1:0]    o;
  logic [NCH-1:0]    busy;
  logic [NCH-1:0]    glitch;

  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  delayprog_multi #(
    .NCH  (NCH),
    .CNTW (CNTW),
    .SYNC (SYNC)
  ) dut (
    .CELCLK     (CELCLK),
    .CELRSTN    (CELRSTN),
    .CELV       (CELV),
    .CELG       (CELG),
    .CELSUB     (CELSUB),
    .i          (i),
    .en         (en),
    .mode       (mode),
    .dly        (dly),
    .glitch_clr (glitch_clr),
    .o          (o),
    .busy       (busy),
    .glitch     (glitch)
  );

  initial begin
    CELCLK = 1'b0;
    forever #5 CELCLK = ~CELCLK;
  end

  // Edge counter: after posedge number N, cyc == N.
  initial cyc = 0;
  always @(posedge CELCLK) cyc <= cyc + 1;

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic push(input int ch, input logic v, input int at_cyc);
    exp_t e;
    e.ch  = ch;
    e.val = v;
    e.cyc = at_cyc;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to just after clock edge t.
  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge CELCLK);
      #1;
    end
  endtask

  // Monitor: every toggle of an o bit must match the oldest expectation for that channel.
  initial begin
    logic [NCH-1:0] prev;
    prev = '0;
    forever begin
      @(negedge CELCLK);
      for (int c = 0; c < NCH; c++) begin
        if (o[c] !== prev[c]) begin
          int idx;
          idx = -1;
          for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].ch == c) begin
              idx = k;
              break;
            end
          end
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_edge ch%0d: o became %b at cyc %0d, none expected", c, o[c], cyc);
          end else begin
            if (sb[idx].val !== o[c] || sb[idx].cyc != cyc) begin
              errors++;
              $display("FAIL edge ch%0d: got o=%b at cyc %0d expected o=%b at cyc %0d",
                       c, o[c], cyc, sb[idx].val, sb[idx].cyc);
            end
            sb.delete(idx);
          end
        end
      end
      prev = o;
    end
  end

  initial begin
    int t;
    checks     = 0;
    errors     = 0;
    CELRSTN    = 1'b0;
    CELV       = 1'b1;
    CELG       = 1'b0;
    CELSUB     = 1'b0;
    i          = '0;
    en         = '1;
    mode       = '0;
    dly        = '0;
    glitch_clr = '0;

    // Reset state
    repeat (3) @(posedge CELCLK);
    #1;
    chk("reset_o", 32'(o), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_glitch", 32'(glitch), 32'h0);
    CELRSTN = 1'b1;
    at(cyc + 2);

    // ch0: rise delay D=9, 20-cycle pulse; fall is undelayed
    t = cyc;
    dly[7:0] = 8'd9;
    i[0] = 1'b1;
    push(0, 1'b1, t + SYNC + 1 + 9 + 1);
    at(t + 2);  chk("t1_busy_before", 32'(busy[0]), 32'h0);
    at(t + 3);  chk("t1_busy_start", 32'(busy[0]), 32'h1);
    at(t + 12); chk("t1_busy_last", 32'(busy[0]), 32'h1);
    at(t + 13); chk("t1_busy_end", 32'(busy[0]), 32'h0);
    chk("t1_o_high", 32'(o[0]), 32'h1);
    at(t + 20);
    i[0] = 1'b0;
    push(0, 1'b0, t + 20 + SYNC + 1);
    at(t + 30);

    // ch1: 5-cycle pulse against D=9 is swallowed and flagged
    t = cyc;
    dly[15:8] = 8'd9;
    i[1] = 1'b1;
    at(t + 5);  i[1] = 1'b0;
    at(t + 7);  chk("t2_glitch_pre", 32'(glitch[1]), 32'h0);
    at(t + 8);  chk("t2_glitch_set", 32'(glitch[1]), 32'h1);
    chk("t2_busy_drop", 32'(busy[1]), 32'h0);
    at(t + 10); glitch_clr[1] = 1'b1;
    at(t + 11); glitch_clr[1] = 1'b0;
    chk("t2_glitch_clr", 32'(glitch[1]), 32'h0);
    at(t + 12); i[1] = 1'b1;
    at(t + 17); i[1] = 1'b0;
    at(t + 19); glitch_clr[1] = 1'b1;
    chk("t2_glitch_pre2", 32'(glitch[1]), 32'h0);
    at(t + 20); glitch_clr[1] = 1'b0;
    chk("t2_set_wins", 32'(glitch[1]), 32'h1);
    at(t + 22); glitch_clr[1] = 1'b1;
    at(t + 23); glitch_clr[1] = 1'b0;
    chk("t2_glitch_clr2", 32'(glitch[1]), 32'h0);
    at(t + 30);

    // ch2: both edges delayed, D=3; dly changed mid-count only affects the next edge
    t = cyc;
    mode[5:4] = 2'b10;
    dly[23:16] = 8'd3;
    i[2] = 1'b1;
    push(2, 1'b1, t + SYNC + 1 + 3 + 1);
    at(t + 4);  dly[23:16] = 8'd7;
    at(t + 10); i[2] = 1'b0;
    push(2, 1'b0, t + 10 + SYNC + 1 + 7 + 1);
    at(t + 30);

    // ch3: bypass, then fall-only delay with D=0
    t = cyc;
    mode[7:6] = 2'b11;
    i[3] = 1'b1;
    push(3, 1'b1, t + SYNC + 1);
    at(t + 6);  i[3] = 1'b0;
    push(3, 1'b0, t + 6 + SYNC + 1);
    at(t + 12);
    mode[7:6] = 2'b01;
    dly[31:24] = 8'd0;
    i[3] = 1'b1;
    push(3, 1'b1, t + 12 + SYNC + 1);
    at(t + 18); i[3] = 1'b0;
    push(3, 1'b0, t + 18 + SYNC + 1 + 0 + 1);
    at(t + 30);

    // ch0: maximum delay D=255, counter must not wrap
    t = cyc;
    dly[7:0] = 8'd255;
    i[0] = 1'b1;
    push(0, 1'b1, t + SYNC + 1 + 255 + 1);
    at(t + 258); chk("t5_busy_late", 32'(busy[0]), 32'h1);
    at(t + 262); i[0] = 1'b0;
    push(0, 1'b0, t + 262 + SYNC + 1);
    at(t + 270);

    // ch1: disable mid-delay, re-enable with input held high restarts a full delay
    t = cyc;
    i[1] = 1'b1;
    at(t + 5);  chk("t6_busy_run", 32'(busy[1]), 32'h1);
    en[1] = 1'b0;
    at(t + 6);  chk("t6_busy_off", 32'(busy[1]), 32'h0);
    chk("t6_glitch_hold", 32'(glitch[1]), 32'h0);
    at(t + 10); en[1] = 1'b1;
    push(1, 1'b1, t + 10 + 1 + 9 + 1);
    at(t + 11); chk("t6_busy_restart", 32'(busy[1]), 32'h1);
    at(t + 25); i[1] = 1'b0;
    push(1, 1'b0, t + 25 + SYNC + 1);
    at(t + 35);

    // ch0: asynchronous reset mid-delay, input held high through release
    t = cyc;
    dly[7:0] = 8'd9;
    i[0] = 1'b1;
    at(t + 5);  chk("t7_busy_run", 32'(busy[0]), 32'h1);
    at(t + 6);
    CELRSTN = 1'b0;
    #1;
    chk("t7_async_busy", 32'(busy), 32'h0);
    chk("t7_async_o", 32'(o), 32'h0);
    chk("t7_async_glitch", 32'(glitch), 32'h0);
    at(t + 8);
    CELRSTN = 1'b1;
    push(0, 1'b1, t + 8 + SYNC + 1 + 9 + 1);
    at(t + 25); i[0] = 1'b0;
    push(0, 1'b0, t + 25 + SYNC + 1);
    at(t + 35);

    // Every queued edge must have been observed
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL missing_edge ch%0d: expected o=%b at cyc %0d, never seen",
               sb[0].ch, sb[0].val, sb[0].cyc);
      sb.delete(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
